block_interleaver_8bit: RTL and testbench
=========================================

Name: block_interleaver_8bit

Overview:
- Row/column block interleaver stage that consumes the byte stream from the 8-bit enabled input register of the interleaver path.
- Buffers one ROWS x COLS block of bytes, written row-major.
- Emits the block column-major to the downstream modulator-side stage.
- Single-buffered: fill phase, then drain phase, with valid/ready handshakes on both sides.

Parameters:
ROWS, 4, number of rows in the interleave matrix (>=2)
COLS, 8, number of columns in the interleave matrix (>=2)
DW, 8, symbol width in bits; fixed at 8 for this path

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream byte valid
in_data  input  DW  upstream byte (from 8-bit register data_out)
in_ready  output  1  block can accept a byte this cycle
out_valid  output  1  interleaved byte available
out_data  output  DW  interleaved byte
out_ready  input  1  downstream accepts byte this cycle
block_done  output  1  one-cycle pulse on acceptance of last byte of a block

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset), sampled on rising clk.
- Storage: ROWS*COLS x DW register array. Write counters wr_row / wr_col; read counters rd_row / rd_col.
- FSM has two states: FILL and DRAIN. Reset state is FILL.
- Reset clears state, all four counters and block_done. Array contents are not reset.
- Reset outputs: in_ready=0 while reset is high. out_valid=0, block_done=0. out_data is don't-care while out_valid=0.
- in_ready = (state==FILL) && !reset. out_valid = (state==DRAIN).
- FILL:
  - Write accepted on in_valid && in_ready: mem[wr_row*COLS+wr_col] <= in_data.
  - wr_col increments; at COLS-1 it wraps to 0 and wr_row increments.
  - On the write to (ROWS-1, COLS-1): counters clear and the next state is DRAIN. in_ready goes low the following cycle.
- DRAIN:
  - out_data = mem[rd_row*COLS+rd_col], combinational from the array. Zero added latency once in DRAIN.
  - Transfer happens on out_valid && out_ready. rd_row increments; at ROWS-1 it wraps to 0 and rd_col increments (column-major).
  - On the transfer of (ROWS-1, COLS-1): counters clear, block_done=1 for exactly that next cycle, and the next state is FILL.
- Output stall: out_data and out_valid hold stable while out_ready=0. No byte is lost or repeated.
- in_valid during DRAIN is ignored (in_ready=0); upstream must hold its byte.
- Latency: first output is valid the cycle after the last input write. Minimum block period is 2*ROWS*COLS cycles.
- Reset mid-operation, in either state: the partial block is discarded and the next accepted byte is written to address 0.
- Simultaneous reset and handshake: reset wins and no write or transfer is counted.
- Address width = clog2(ROWS*COLS). Counter widths = clog2(ROWS) and clog2(COLS), minimum 1 bit each.

Optional Feature:
- Macro: INTLV_BLKCNT_EN.
- When defined: adds output port blk_count, 8 bits.
  - Reset to 0; increments by 1 in the cycle block_done is asserted.
  - Wraps 255 -> 0.
- When undefined: the port and counter are absent; the rest of the behaviour is identical.

Test Plan:
- Basic order (ROWS=4, COLS=8): write bytes 0..31 with in_valid held high and out_ready=1 -> outputs 0,8,16,24,1,9,17,25,...,7,15,23,31. block_done pulses once after byte 31 is accepted.
- Backpressure: during DRAIN, drop out_ready low for 5 cycles after byte 9 is presented -> out_data stays 9 and out_valid stays 1 for those cycles; the sequence resumes unchanged.
- Input held off in DRAIN: keep in_valid=1 with data 0xAA throughout DRAIN -> in_ready=0 for all 32 drain cycles. The next block's first stored byte is the value presented once in_ready returns to 1.
- Reset mid-fill: write 0x10..0x19 (10 bytes), assert reset for 1 cycle, then write 0x40..0x5F -> the output block is 0x40,0x48,0x50,0x58,0x41,... with no 0x1x values.
- Back-to-back blocks: stream 64 bytes (0..63) with out_ready=1 -> two correctly interleaved blocks and two block_done pulses. With INTLV_BLKCNT_EN, blk_count reads 2 at the end.
- Irregular handshakes: random in_valid/out_ready at 50% density over 10 blocks -> every block is correctly permuted, with no drops or duplicates (scoreboard).

Source files
------------

// File: rtl/block_interleaver_8bit.sv
// Row/column block interleaver: buffers ROWS x COLS bytes written row-major, then drains them column-major.
// Optional build macro INTLV_BLKCNT_EN adds an 8-bit wrapping completed-block counter port (blk_count).
module block_interleaver_8bit #(
    parameter int ROWS = 4,
    parameter int COLS = 8,
    parameter int DW   = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          block_done
`ifdef INTLV_BLKCNT_EN
    ,
    output logic [7:0]    blk_count
`endif
);

    localparam int DEPTH = ROWS * COLS;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t        state;
    logic [RW-1:0] wr_row, rd_row;
    logic [CW-1:0] wr_col, rd_col;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_addr, rd_addr;
    logic          wr_en, rd_en, wr_last, rd_last;

    assign wr_addr = AW'(wr_row) * AW'(COLS) + AW'(wr_col);
    assign rd_addr = AW'(rd_row) * AW'(COLS) + AW'(rd_col);

    // Reset gates the handshakes directly so a colliding beat is never counted.
    assign in_ready  = (state == FILL) && !reset;
    assign out_valid = (state == DRAIN);
    assign out_data  = mem[rd_addr];

    assign wr_en   = in_valid && in_ready;
    assign rd_en   = out_valid && out_ready && !reset;
    assign wr_last = (wr_row == ROW_MAX) && (wr_col == COL_MAX);
    assign rd_last = (rd_row == ROW_MAX) && (rd_col == COL_MAX);

    // NOTE: storage has no reset; contents are only observable after a full block is written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= in_data;
        end
    end

    // NOTE: all sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FILL;
            wr_row     <= '0;
            wr_col     <= '0;
            rd_row     <= '0;
            rd_col     <= '0;
            block_done <= 1'b0;
`ifdef INTLV_BLKCNT_EN
            blk_count  <= 8'd0;
`endif
        end else begin
            block_done <= 1'b0;
            case (state)
                FILL: begin
                    if (wr_en) begin
                        if (wr_last) begin
                            wr_row <= '0;
                            wr_col <= '0;
                            state  <= DRAIN;
                        end else if (wr_col == COL_MAX) begin
                            wr_col <= '0;
                            wr_row <= wr_row + 1'b1;
                        end else begin
                            wr_col <= wr_col + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Column-major walk: rows advance fastest.
                    if (rd_en) begin
                        if (rd_last) begin
                            rd_row     <= '0;
                            rd_col     <= '0;
                            block_done <= 1'b1;
`ifdef INTLV_BLKCNT_EN
                            blk_count  <= blk_count + 8'd1;
`endif
                            state      <= FILL;
                        end else if (rd_row == ROW_MAX) begin
                            rd_row <= '0;
                            rd_col <= rd_col + 1'b1;
                        end else begin
                            rd_row <= rd_row + 1'b1;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_block_interleaver_8bit.sv
// Self-checking bench for block_interleaver_8bit: directed and random handshakes against a
// queue-based permutation model that predicts readiness, output order and block_done pulses.
module tb_block_interleaver_8bit;

    localparam int ROWS = 4;
    localparam int COLS = 8;
    localparam int N    = ROWS * COLS;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       block_done;
`ifdef INTLV_BLKCNT_EN
    logic [7:0] blk_count;
`endif

    block_interleaver_8bit #(.ROWS(ROWS), .COLS(COLS), .DW(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .block_done (block_done)
`ifdef INTLV_BLKCNT_EN
        ,
        .blk_count  (blk_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: bytes of the block being collected, and the expected column-major output order.
    logic [7:0] fill_buf [N];
    int         in_cnt  = 0;
    logic [7:0] exp_q [$];
    logic [7:0] src_q [$];
    int         blk_cnt = 0;

    task automatic check(input logic [7:0] observed, input logic [7:0] expected, input string tag);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock: drive after negedge, check pre-edge outputs, advance model at posedge, check block_done.
    task automatic tick(input bit iv, input logic [7:0] d, input bit ordy, output bit acc_in);
        bit acc_out;
        bit done_exp;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        check(in_ready,  (exp_q.size() == 0), "in_ready");
        check(out_valid, (exp_q.size() != 0), "out_valid");
        if (exp_q.size() != 0) check(out_data, exp_q[0], "out_data");
        acc_in  = iv && (exp_q.size() == 0);
        acc_out = ordy && (exp_q.size() != 0);
        @(posedge clk);
        done_exp = 1'b0;
        if (acc_out) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin
                done_exp = 1'b1;
                blk_cnt  = (blk_cnt + 1) % 256;
            end
        end
        if (acc_in) begin
            fill_buf[in_cnt] = d;
            in_cnt++;
            if (in_cnt == N) begin
                for (int c = 0; c < COLS; c++)
                    for (int r = 0; r < ROWS; r++)
                        exp_q.push_back(fill_buf[r * COLS + c]);
                in_cnt = 0;
            end
        end
        #1;
        check(block_done, done_exp, "block_done");
`ifdef INTLV_BLKCNT_EN
        check(blk_count, 8'(blk_cnt), "blk_count");
`endif
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset     = 1'b1;
            in_valid  = 1'b1;
            in_data   = 8'hEE;
            out_ready = 1'b1;
            #1;
            check(in_ready, 1'b0, "in_ready_during_reset");
            @(posedge clk);
        end
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        in_cnt   = 0;
        exp_q.delete();
        blk_cnt  = 0;
        #1;
        check(out_valid,  1'b0, "out_valid_after_reset");
        check(block_done, 1'b0, "block_done_after_reset");
        check(in_ready,   1'b1, "in_ready_after_reset");
`ifdef INTLV_BLKCNT_EN
        check(blk_count, 8'd0, "blk_count_after_reset");
`endif
    endtask

    // Push src_q through the DUT with given percent densities until the model is idle.
    task automatic stream(input int p_in, input int p_out, input int max_cyc, input string tag);
        int cyc = 0;
        bit iv, ordy, acc;
        while ((src_q.size() != 0 || exp_q.size() != 0 || in_cnt != 0) && cyc < max_cyc) begin
            iv   = (src_q.size() != 0) && ($urandom_range(99) < p_in);
            ordy = ($urandom_range(99) < p_out);
            tick(iv, iv ? src_q[0] : 8'($urandom), ordy, acc);
            if (acc) void'(src_q.pop_front());
            cyc++;
        end
        check(8'(cyc < max_cyc), 8'd1, {tag, "_timeout"});
    endtask

    initial begin
        bit acc;
        bit ordy;
        int stall;
        int cyc;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        do_reset(2);

        // Basic order: 0..31 in, 0,8,16,24,1,... out.
        for (int i = 0; i < N; i++) src_q.push_back(8'(i));
        stream(100, 100, 200, "basic");

        // Backpressure: hold out_ready low 5 cycles while byte 9 is presented.
        for (int i = 0; i < N; i++) tick(1'b1, 8'(i), 1'b1, acc);
        stall = 0;
        cyc   = 0;
        while (exp_q.size() != 0 && cyc < 64) begin
            ordy = 1'b1;
            if (exp_q[0] == 8'd9 && stall < 5) begin
                ordy = 1'b0;
                stall++;
            end
            tick(1'b0, 8'h00, ordy, acc);
            cyc++;
        end

        // Input held during DRAIN: 0xAA presented throughout must become the next block's first byte.
        for (int i = 0; i < N; i++) src_q.push_back(8'(8'h80 + i));
        src_q.push_back(8'hAA);
        for (int i = 1; i < N; i++) src_q.push_back(8'(8'hC0 + i));
        stream(100, 100, 300, "held_input");

        // Reset mid-fill discards the partial block.
        for (int i = 0; i < 10; i++) tick(1'b1, 8'(8'h10 + i), 1'b1, acc);
        do_reset(1);
        for (int i = 0; i < N; i++) src_q.push_back(8'(8'h40 + i));
        stream(100, 100, 200, "after_reset");

        // Back-to-back blocks from a clean counter.
        do_reset(1);
        for (int i = 0; i < 2 * N; i++) src_q.push_back(8'(i));
        stream(100, 100, 400, "back_to_back");
`ifdef INTLV_BLKCNT_EN
        check(blk_count, 8'd2, "blk_count_two_blocks");
`endif

        // Irregular handshakes over 10 random blocks.
        for (int i = 0; i < 10 * N; i++) src_q.push_back(8'($urandom));
        stream(50, 50, 4000, "random");

        // Reset while draining.
        for (int i = 0; i < N; i++) tick(1'b1, 8'($urandom), 1'b0, acc);
        tick(1'b0, 8'h00, 1'b1, acc);
        do_reset(1);
        for (int i = 0; i < N; i++) src_q.push_back(8'(8'hF0 - i));
        stream(100, 100, 200, "reset_in_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
